// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decoder for the seven-segment blocks.
// Segment encoding is active-low, bit order gfedcba (seg[0]=a ... seg[6]=g).
package seven_seg_pkg;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry k holds the active-low pattern for hex digit k (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Free-running refresh prescaler: counts 0..REFRESH_DIV-1 and raises tick
// for the single cycle spent at the terminal count.
module seven_seg_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_LAST);

  // Count up, returning to zero after the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// New words are taken through a valid/ready handshake and only reach the
// display registers when the scan wraps, so a frame never mixes two words.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits
// at commit; digit 0 is never auto-blanked).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  frame_start,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic                  tick;
  logic [IDX_W-1:0]      idx_reg;
  logic                  frame_start_reg;
  logic                  pending_reg;
  logic [4*DIGITS-1:0]   pend_data_reg;
  logic [DIGITS-1:0]     pend_dp_reg;
  logic [DIGITS-1:0]     pend_blank_reg;
  logic [4*DIGITS-1:0]   disp_data_reg;
  logic [DIGITS-1:0]     disp_dp_reg;
  logic [DIGITS-1:0]     disp_blank_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic [DIGITS-1:0]     an_reg;

  logic                  commit;
  logic                  accept;
  logic [4*DIGITS-1:0]   src_data;
  logic [DIGITS-1:0]     src_dp;
  logic [DIGITS-1:0]     src_blank;
  logic [DIGITS-1:0]     commit_blank;
  logic [3:0]            disp_nib [DIGITS];

  seven_seg_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // The last tick of the last digit closes the frame: that is where updates land.
  assign commit     = tick && (idx_reg == IDX_LAST);
  assign accept     = load_valid && !pending_reg;
  assign load_ready = !pending_reg;
  assign frame_start = frame_start_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;

  // Word to commit: a same-cycle accept bypasses the pending registers.
  always_comb begin
    src_data  = pend_data_reg;
    src_dp    = pend_dp_reg;
    src_blank = pend_blank_reg;
    if (accept) begin
      src_data  = data_in;
      src_dp    = dp_in;
      src_blank = blank_in;
    end
  end

  // Slice the displayed word into per-digit nibbles for the scan mux.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign disp_nib[gi] = disp_data_reg[4*gi +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k]: every nibble from the top digit down to k is zero.
  logic [DIGITS:1] lead_zero;
  logic [DIGITS-1:0] lz_mask;
  assign lead_zero[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_keep0
      assign lz_mask[0] = 1'b0;
    end else begin : g_blank
      assign lead_zero[gi] = lead_zero[gi+1] && (src_data[4*gi +: 4] == 4'h0);
      assign lz_mask[gi]   = lead_zero[gi];
    end
  end
  assign commit_blank = src_blank | lz_mask;
`else
  assign commit_blank = src_blank;
`endif

  // Digit index and the wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= commit;
      if (tick) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // Handshake capture and frame-boundary commit into the display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg    <= 1'b0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      disp_data_reg  <= '0;
      disp_dp_reg    <= '0;
      disp_blank_reg <= '0;
    end else if (commit) begin
      pending_reg <= 1'b0;
      if (accept || pending_reg) begin
        disp_data_reg  <= src_data;
        disp_dp_reg    <= src_dp;
        disp_blank_reg <= commit_blank;
      end
    end else if (accept) begin
      pending_reg    <= 1'b1;
      pend_data_reg  <= data_in;
      pend_dp_reg    <= dp_in;
      pend_blank_reg <= blank_in;
    end
  end

  // Registered pin drivers, one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= '1;
      seg_reg <= SEG_OFF;
      dp_reg  <= 1'b1;
    end else begin
      an_reg <= ~(DIGITS'(1) << idx_reg);
      if (disp_blank_reg[idx_reg]) begin
        seg_reg <= SEG_OFF;
        dp_reg  <= 1'b1;
      end else begin
        seg_reg <= hex_to_seg(disp_nib[idx_reg]);
        dp_reg  <= ~disp_dp_reg[idx_reg];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4).
// A time-based reference model predicts every output on every cycle; table
// vectors and hand sequences add per-digit checks of whole frames.
module tb_seven_seg_scan;

  localparam int D   = 4;
  localparam int DIV = 4;

  logic          clk;
  logic          rst;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          load_valid;
  logic          load_ready;
  logic          frame_start;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  int tests = 0;
  int fails = 0;

  seven_seg_scan #(
    .DIGITS(D),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .frame_start(frame_start),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_n;          // cycles since reset release
  logic [15:0] m_data;
  logic [3:0]  m_dpd;
  logic [3:0]  m_blank;
  logic        m_pend;
  logic [15:0] m_pdata;
  logic [3:0]  m_pdp;
  logic [3:0]  m_pblank;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;
  logic        e_ready;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [3:0] ref_lz(input logic [15:0] d);
    logic [3:0] m;
    m = 4'b0000;
    for (int k = 3; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'h0) break;
      m[k] = 1'b1;
    end
    return m;
  endfunction
`endif

  task automatic install(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    m_data = d;
    m_dpd  = p;
`ifdef LEADING_ZERO_BLANK_EN
    m_blank = b | ref_lz(d);
`else
    m_blank = b;
`endif
  endtask

  // Predict the outputs seen after the coming clock edge from the current inputs.
  task automatic model_edge();
    int   idx;
    logic commit;
    logic accept;
    if (rst) begin
      m_n = 0; m_data = '0; m_dpd = '0; m_blank = '0;
      m_pend = 1'b0; m_pdata = '0; m_pdp = '0; m_pblank = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_ready = 1'b1;
    end else begin
      idx    = (m_n / DIV) % D;
      commit = ((m_n % DIV) == DIV - 1) && (idx == D - 1);
      e_an   = ~(4'b0001 << idx);
      if (m_blank[idx]) begin
        e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_seg = ref_seg(m_data[4*idx +: 4]); e_dp = ~m_dpd[idx];
      end
      e_fs   = commit;
      accept = load_valid && !m_pend;
      if (commit) begin
        if (accept) install(data_in, dp_in, blank_in);
        else if (m_pend) install(m_pdata, m_pdp, m_pblank);
        m_pend = 1'b0;
      end else if (accept) begin
        m_pend = 1'b1; m_pdata = data_in; m_pdp = dp_in; m_pblank = blank_in;
      end
      e_ready = !m_pend;
      m_n++;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: predict, advance, then compare every output with the model.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_outputs", 32'({an, seg, dp, frame_start, load_ready}),
        32'({e_an, e_seg, e_dp, e_fs, e_ready}));
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    int g;
    g = 0;
    while (!load_ready && g < 64) begin
      cycle();
      g++;
    end
    chk("wait_ready", 32'(load_ready), 32'd1);
    data_in = d; dp_in = p; blank_in = b; load_valid = 1'b1;
    $display("[TB] load data=%h dp=%b blank=%b", d, p, b);
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int g;
    g = 0;
    do begin
      cycle();
      g++;
    end while (!frame_start && g < 64);
    chk("wait_frame", 32'(frame_start), 32'd1);
  endtask

  // Watch one full frame following a frame_start sample and compare each digit.
  task automatic scan_frame(input string name, input logic [3:0][6:0] xs, input logic [3:0] xd);
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    gs = '1;
    gd = '0;
    repeat (D * DIV) begin
      cycle();
      for (int k = 0; k < D; k++) begin
        if (an[k] == 1'b0) begin
          gs[k] = seg;
          gd[k] = dp;
        end
      end
    end
    for (int k = 0; k < D; k++) begin
      chk($sformatf("%s_digit%0d", name, k), 32'({gs[k], gd[k]}), 32'({xs[k], xd[k]}));
    end
    $display("[TB] frame %s seg=%h %h %h %h dp=%b", name, gs[3], gs[2], gs[1], gs[0], gd);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;   // expected {digit3, digit2, digit1, digit0}
    logic [3:0]      dpo;   // expected active-low dp per digit
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h1234, 4'b0010, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101};
    vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'h5678, 4'b1001, 4'b0000, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0110};
    vecs[3] = '{16'h9ABC, 4'b0000, 4'b0000, {7'h10, 7'h08, 7'h03, 7'h46}, 4'b1111};
    vecs[4] = '{16'hDEF0, 4'b0100, 4'b0000, {7'h21, 7'h06, 7'h0E, 7'h40}, 4'b1011};
    vecs[5] = '{16'h0E00, 4'b1000, 4'b1000, {7'h7F, 7'h06, 7'h40, 7'h40}, 4'b1111};
    vecs[6] = '{16'hFFFF, 4'b1111, 4'b0000, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000};

    rst = 1'b1; data_in = '0; dp_in = '0; blank_in = '0; load_valid = 1'b0;

    // Reset state.
    repeat (3) cycle();
    chk("reset_outputs", 32'({an, seg, dp, frame_start, load_ready}),
        32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}));
    rst = 1'b0;
    cycle();
    chk("first_digit_an", 32'(an), 32'(4'b1110));

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      load_word(vecs[i].data, vecs[i].dp, vecs[i].blank);
      wait_frame();
      scan_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpo);
    end

    // No-tear: a mid-frame load waits for the wrap.
    load_word(16'h1234, 4'b0010, 4'b0000);
    wait_frame();
    repeat (5) cycle();
    load_word(16'hABCD, 4'b0000, 4'b0000);
    chk("pending_ready_low", 32'(load_ready), 32'd0);
    wait_frame();
    chk("ready_after_commit", 32'(load_ready), 32'd1);
    scan_frame("notear", {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111);

    // Accept on the commit tick bypasses straight to the display.
    begin
      int g;
      g = 0;
      while ((m_n % (D * DIV)) != (D * DIV - 1) && g < 40) begin
        cycle();
        g++;
      end
    end
    data_in = 16'hFFFF; dp_in = 4'b0000; blank_in = 4'b0000; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    chk("bypass_ready", 32'(load_ready), 32'd1);
    chk("bypass_frame_start", 32'(frame_start), 32'd1);
    scan_frame("bypass", {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1111);

    // Leading zero handling.
    load_word(16'h0050, 4'b0000, 4'b0000);
    wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
    scan_frame("lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
`else
    scan_frame("lz_0050", {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111);
`endif
    load_word(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
    scan_frame("lz_0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
`else
    scan_frame("lz_0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
`endif

    // Reset mid-frame with an update pending: the update is discarded.
    load_word(16'h1234, 4'b0010, 4'b0000);
    wait_frame();
    repeat (3) cycle();
    load_word(16'h5678, 4'b1111, 4'b0000);
    rst = 1'b1;
    cycle();
    chk("midreset_outputs", 32'({an, seg, dp, frame_start, load_ready}),
        32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}));
    rst = 1'b0;
    wait_frame();
    scan_frame("after_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    // Randomised traffic against the model.
    $display("[TB] random phase");
    repeat (1500) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      data_in    = 16'($urandom);
      dp_in      = 4'($urandom);
      blank_in   = 4'($urandom);
      cycle();
    end
    rst = 1'b0; load_valid = 1'b0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
